// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the bus command arbiter.
//   BUS_RD / BUS_WR  - command op encoding
//   arb_mode_e       - arbitration policy (round-robin or fixed priority)
//   clog2()          - channel-index width, never less than 1 bit
package bus_pkg;

  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// bus_arb_pick: combinational one-hot request picker.
//   req_i   - request vector, one bit per channel
//   ptr_i   - round-robin start index (ignored in ARB_FIXED)
//   grant_o - one-hot grant, zero when no request
//   idx_o   - binary index of the granted channel (0 when none)
module bus_arb_pick
  import bus_pkg::*;
#(
  parameter int        NUM_CH   = 4,
  parameter arb_mode_e ARB_MODE = ARB_RR,
  localparam int       IW       = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IW-1:0]     idx_o
);

  always_comb begin
    int   start;
    int   c;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    c       = 0;
    start   = (ARB_MODE == ARB_RR) ? int'(ptr_i) : 0;
    // Scan upward from the start index, wrapping past the top channel.
    for (int k = 0; k < NUM_CH; k++) begin
      c = start + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && req_i[c]) begin
        found      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/bus_cmd_arb.sv
// bus_cmd_arb: arbitrates NUM_CH upstream command channels onto one
// downstream bus and routes read data back to the issuing channel.
//   clk, rst                       - clock, synchronous active-high reset
//   ch_cmd_valid / ch_cmd_ready    - per-channel command handshake
//   ch_op, ch_addr, ch_wr_data     - per-channel command payload (packed)
//   ch_rd_valid, ch_rd_data        - read return strobe and shared data
//   bus_cmd_valid, bus_op,
//   bus_addr, bus_wr_data          - registered downstream command
//   bus_rd_data                    - downstream read data, RD_LATENCY after cmd
module bus_cmd_arb
  import bus_pkg::*;
#(
  parameter int        ADDR_WIDTH = 16,
  parameter int        DATA_WIDTH = 16,
  parameter int        NUM_CH     = 4,
  parameter int        RD_LATENCY = 1,
  parameter arb_mode_e ARB_MODE   = ARB_RR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_cmd_valid,
  output logic [NUM_CH-1:0]            ch_cmd_ready,
  input  logic [NUM_CH-1:0]            ch_op,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wr_data,
  output logic [NUM_CH-1:0]            ch_rd_valid,
  output logic [DATA_WIDTH-1:0]        ch_rd_data,
  output logic                         bus_cmd_valid,
  output logic                         bus_op,
  output logic [ADDR_WIDTH-1:0]        bus_addr,
  output logic [DATA_WIDTH-1:0]        bus_wr_data,
  input  logic [DATA_WIDTH-1:0]        bus_rd_data
);

  localparam int IW = clog2(NUM_CH);

  logic [NUM_CH-1:0]     grant;
  logic [IW-1:0]         grant_idx;
  logic                  xfer;
  logic [IW-1:0]         ptr_q, ptr_d;

  logic                  bus_valid_q;
  logic                  bus_op_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;
  logic [IW-1:0]         bus_idx_q;

  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [IW-1:0]         tag_idx_q [RD_LATENCY];
  logic [NUM_CH-1:0]     rd_vld_d, rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  bus_arb_pick #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_pick (
    .req_i   (ch_cmd_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  // No channel is accepted while reset is held.
  assign ch_cmd_ready = rst ? '0 : grant;
  assign xfer         = |ch_cmd_ready;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && (ARB_MODE == ARB_RR)) begin
      ptr_d = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_op_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_idx_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      bus_valid_q <= xfer;
      // Payload holds its last value between transfers.
      if (xfer) begin
        bus_op_q    <= ch_op[grant_idx];
        bus_addr_q  <= ch_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        bus_wdata_q <= ch_wr_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        bus_idx_q   <= grant_idx;
      end
    end
  end

  // Read tag leaving the last stage marks the cycle bus_rd_data is valid.
  always_comb begin
    rd_vld_d = '0;
    if (tag_vld_q[RD_LATENCY-1]) rd_vld_d[tag_idx_q[RD_LATENCY-1]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_idx_q[i] <= '0;
      rd_vld_q  <= '0;
      rd_data_q <= '0;
    end else begin
      tag_vld_q[0] <= bus_valid_q && (bus_op_q == BUS_RD);
      tag_idx_q[0] <= bus_idx_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
      rd_vld_q <= rd_vld_d;
      if (tag_vld_q[RD_LATENCY-1]) rd_data_q <= bus_rd_data;
    end
  end

  assign bus_cmd_valid = bus_valid_q;
  assign bus_op        = bus_op_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wr_data   = bus_wdata_q;
  assign ch_rd_valid   = rd_vld_q;
  assign ch_rd_data    = rd_data_q;

endmodule

// File: tb/tb_bus_cmd_arb.sv
module tb_bus_cmd_arb;
  import bus_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int NC  = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NC-1:0]    ch_cmd_valid, ch_op;
  logic [NC*AW-1:0] ch_addr;
  logic [NC*DW-1:0] ch_wr_data;
  logic [DW-1:0]    bus_rd_data;

  logic [NC-1:0] rr_ready, rr_rd_valid, fx_ready, fx_rd_valid;
  logic [DW-1:0] rr_rd_data, fx_rd_data, rr_bus_wdata, fx_bus_wdata;
  logic [AW-1:0] rr_bus_addr, fx_bus_addr;
  logic          rr_bus_valid, rr_bus_op, fx_bus_valid, fx_bus_op;

  bus_cmd_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC), .RD_LATENCY(LAT), .ARB_MODE(ARB_RR)) dut_rr (
    .clk(clk), .rst(rst), .ch_cmd_valid(ch_cmd_valid), .ch_cmd_ready(rr_ready), .ch_op(ch_op),
    .ch_addr(ch_addr), .ch_wr_data(ch_wr_data), .ch_rd_valid(rr_rd_valid), .ch_rd_data(rr_rd_data),
    .bus_cmd_valid(rr_bus_valid), .bus_op(rr_bus_op), .bus_addr(rr_bus_addr),
    .bus_wr_data(rr_bus_wdata), .bus_rd_data(bus_rd_data));

  bus_cmd_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC), .RD_LATENCY(LAT), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .rst(rst), .ch_cmd_valid(ch_cmd_valid), .ch_cmd_ready(fx_ready), .ch_op(ch_op),
    .ch_addr(ch_addr), .ch_wr_data(ch_wr_data), .ch_rd_valid(fx_rd_valid), .ch_rd_data(fx_rd_data),
    .bus_cmd_valid(fx_bus_valid), .bus_op(fx_bus_op), .bus_addr(fx_bus_addr),
    .bus_wr_data(fx_bus_wdata), .bus_rd_data(bus_rd_data));

  typedef struct {
    logic       r;
    logic [3:0] vld;
    logic [3:0] op;
    logic [3:0] exp_rr;
    logic [3:0] exp_fx;
  } vec_t;

  typedef struct {
    int          due;
    logic        op;
    logic [15:0] addr;
    logic [15:0] data;
  } cmd_t;

  typedef struct {
    int due;
    int ch;
  } rdr_t;

  cmd_t        cmd_q[$];
  rdr_t        rd_q[$];
  logic [15:0] rd_hist [0:255];

  int          cyc, n_chk, n_err;
  logic        last_op;
  logic [15:0] last_addr, last_data, last_rd;
  logic        ov_en;
  int          ov_ch;
  logic [15:0] ov_addr, ov_data;

  function automatic logic [15:0] gen_addr(input int ch, input int c);
    return 16'((ch << 12) | (c & 'hfff));
  endfunction

  function automatic logic [15:0] gen_data(input int ch, input int c);
    return 16'h5A00 ^ 16'((c << 4) | ch);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: check registered outputs against the scoreboard, drive
  // new inputs, check the combinational grant, then record what must appear.
  task automatic run_cycle(input logic r, input logic [3:0] vld, input logic [3:0] op,
                           input logic [3:0] exp_rr, input logic [3:0] exp_fx,
                           input logic [15:0] rdv);
    cmd_t cm;
    rdr_t rt;
    int   g;
    @(posedge clk);
    #1;
    cyc++;
    if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
      cm = cmd_q.pop_front();
      chk("bus_valid", 32'(rr_bus_valid), 32'(1));
      chk("bus_op", 32'(rr_bus_op), 32'(cm.op));
      chk("bus_addr", 32'(rr_bus_addr), 32'(cm.addr));
      chk("bus_wdata", 32'(rr_bus_wdata), 32'(cm.data));
      last_op = cm.op; last_addr = cm.addr; last_data = cm.data;
    end else begin
      chk("bus_idle", 32'(rr_bus_valid), 32'(0));
      chk("bus_op_hold", 32'(rr_bus_op), 32'(last_op));
      chk("bus_addr_hold", 32'(rr_bus_addr), 32'(last_addr));
      chk("bus_wdata_hold", 32'(rr_bus_wdata), 32'(last_data));
    end
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      rt = rd_q.pop_front();
      chk("rd_valid", 32'(rr_rd_valid), 32'(1 << rt.ch));
      chk("rd_data", 32'(rr_rd_data), 32'(rd_hist[cyc-1]));
      last_rd = rd_hist[cyc-1];
    end else begin
      chk("rd_quiet", 32'(rr_rd_valid), 32'(0));
      chk("rd_data_hold", 32'(rr_rd_data), 32'(last_rd));
    end

    rst          = r;
    ch_cmd_valid = vld;
    ch_op        = op;
    bus_rd_data  = rdv;
    rd_hist[cyc] = rdv;
    for (int i = 0; i < NC; i++) begin
      ch_addr[i*AW +: AW]    = (ov_en && ov_ch == i) ? ov_addr : gen_addr(i, cyc);
      ch_wr_data[i*DW +: DW] = (ov_en && ov_ch == i) ? ov_data : gen_data(i, cyc);
    end
    #1;
    chk("rr_grant", 32'(rr_ready), 32'(exp_rr));
    chk("fx_grant", 32'(fx_ready), 32'(exp_fx));

    if (r) begin
      cmd_q.delete();
      rd_q.delete();
      last_op = 1'b0; last_addr = '0; last_data = '0; last_rd = '0;
    end else begin
      g = -1;
      for (int i = 0; i < NC; i++) if (exp_rr[i]) g = i;
      if (g >= 0) begin
        cm.due  = cyc + 1;
        cm.op   = op[g];
        cm.addr = ch_addr[g*AW +: AW];
        cm.data = ch_wr_data[g*DW +: DW];
        cmd_q.push_back(cm);
        if (op[g] == BUS_RD) begin
          rt.due = cyc + LAT + 2;
          rt.ch  = g;
          rd_q.push_back(rt);
        end
      end
    end
  endtask

  vec_t vt[17];

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_chk = 0; n_err = 0;
    last_op = 1'b0; last_addr = '0; last_data = '0; last_rd = '0;
    ov_en = 1'b0; ov_ch = 0; ov_addr = '0; ov_data = '0;
    rst = 1'b1; ch_cmd_valid = '0; ch_op = '0; ch_addr = '0; ch_wr_data = '0; bus_rd_data = '0;
    for (int i = 0; i < 256; i++) rd_hist[i] = '0;
    repeat (2) @(posedge clk);

    //          rst   vld    op     rr     fixed
    vt[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0};  // reset: nothing accepted
    vt[1]  = '{1'b0, 4'hF, 4'h0, 4'h1, 4'h1};  // rotation 0,1,2,3,0,1
    vt[2]  = '{1'b0, 4'hF, 4'h0, 4'h2, 4'h1};
    vt[3]  = '{1'b0, 4'hF, 4'h0, 4'h4, 4'h1};
    vt[4]  = '{1'b0, 4'hF, 4'h0, 4'h8, 4'h1};
    vt[5]  = '{1'b0, 4'hF, 4'hF, 4'h1, 4'h1};
    vt[6]  = '{1'b0, 4'hF, 4'hF, 4'h2, 4'h1};
    vt[7]  = '{1'b0, 4'h4, 4'h0, 4'h4, 4'h4};  // pointer -> 3
    vt[8]  = '{1'b0, 4'h9, 4'h0, 4'h8, 4'h1};  // ch3 then wrap to ch0
    vt[9]  = '{1'b0, 4'h9, 4'h0, 4'h1, 4'h1};
    vt[10] = '{1'b0, 4'hA, 4'hF, 4'h2, 4'h2};  // fixed keeps ch1, never ch3
    vt[11] = '{1'b0, 4'hA, 4'hF, 4'h8, 4'h2};
    vt[12] = '{1'b0, 4'hA, 4'hF, 4'h2, 4'h2};
    vt[13] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[14] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[15] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[16] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0};

    for (int i = 0; i < 17; i++)
      run_cycle(vt[i].r, vt[i].vld, vt[i].op, vt[i].exp_rr, vt[i].exp_fx, 16'hD000 + 16'(i * 'h111));

    // ch2 write 0x0010 / 0xBEEF (pointer is 2 here)
    ov_en = 1'b1; ov_ch = 2; ov_addr = 16'h0010; ov_data = 16'hBEEF;
    run_cycle(1'b0, 4'h4, 4'h4, 4'h4, 4'h4, 16'h0);
    ov_en = 1'b0;
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    chk("wr_direct_valid", 32'(rr_bus_valid), 32'(1));
    chk("wr_direct_op", 32'(rr_bus_op), 32'(1));
    chk("wr_direct_addr", 32'(rr_bus_addr), 32'h0010);
    chk("wr_direct_data", 32'(rr_bus_wdata), 32'hBEEF);
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);

    // ch0 read at T, ch3 read at T+1 (pointer is 3 here)
    run_cycle(1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 16'h0);      // T
    run_cycle(1'b0, 4'h8, 4'h0, 4'h8, 4'h8, 16'h0);      // T+1
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);      // T+2
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h1111);   // T+3
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h3333);   // T+4
    chk("rd0_direct_valid", 32'(rr_rd_valid), 32'h1);
    chk("rd0_direct_data", 32'(rr_rd_data), 32'h1111);
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);      // T+5
    chk("rd3_direct_valid", 32'(rr_rd_valid), 32'h8);
    chk("rd3_direct_data", 32'(rr_rd_data), 32'h3333);
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);

    // ch1 read, reset pulsed before its return (pointer is 0 here)
    run_cycle(1'b0, 4'h2, 4'h0, 4'h2, 4'h2, 16'h0);
    run_cycle(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 16'h7777);
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h7777);
    chk("rst_bus_valid", 32'(rr_bus_valid), 32'(0));
    chk("rst_rd_data", 32'(rr_rd_data), 32'(0));
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h7777);
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h7777);
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h7777);
    run_cycle(1'b0, 4'hF, 4'hF, 4'h1, 4'h1, 16'h0);      // pointer restarts at 0
    run_cycle(1'b0, 4'hF, 4'hF, 4'h2, 4'h1, 16'h0);
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    run_cycle(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);

    chk("drain", 32'(cmd_q.size() + rd_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_cmd_arb.md
BUS_CMD_ARB -- requirements
Module: bus_cmd_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, address width of every channel and of the downstream bus.
REQ-002 Parameter DATA_WIDTH, default 16, write and read data width.
REQ-003 Parameter NUM_CH, default 4, number of upstream command channels, range 2..16.
REQ-004 Parameter RD_LATENCY, default 1, cycles from a downstream read command to valid bus_rd_data, range 1..8.
REQ-005 Parameter ARB_MODE, default ARB_RR, arbitration policy: ARB_RR (round-robin) or ARB_FIXED (channel 0 highest priority).
REQ-006 Port clk, input, 1, single clock; all logic on the rising edge.
REQ-007 Port rst, input, 1, reset, synchronous, active-high.
REQ-008 Port ch_cmd_valid, input, NUM_CH, per-channel command request.
REQ-009 Port ch_cmd_ready, output, NUM_CH, per-channel accept; a command transfers when valid and ready are both 1.
REQ-010 Port ch_op, input, NUM_CH, per-channel op: BUS_RD=0, BUS_WR=1.
REQ-011 Port ch_addr, input, NUM_CH*ADDR_WIDTH, channel i in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 Port ch_wr_data, input, NUM_CH*DATA_WIDTH, packed the same way as ch_addr.
REQ-013 Port ch_rd_valid, output, NUM_CH, one-cycle read-return strobe for the owning channel.
REQ-014 Port ch_rd_data, output, DATA_WIDTH, read data shared by all channels; qualified by ch_rd_valid.
REQ-015 Ports bus_cmd_valid (output, 1), bus_op (output, 1), bus_addr (output, ADDR_WIDTH), bus_wr_data (output, DATA_WIDTH), bus_rd_data (input, DATA_WIDTH): the downstream bus.

Function
REQ-016 At most one ch_cmd_ready bit is high per cycle: the granted channel.
REQ-017 Grant is combinational from ch_cmd_valid and the priority pointer; ch_cmd_ready is 0 for channels with ch_cmd_valid=0.
REQ-018 ARB_RR grants the first valid channel at or after the pointer, scanning upward with wrap from NUM_CH-1 to 0.
REQ-019 ARB_RR pointer becomes (granted index + 1) mod NUM_CH after each transfer and holds when no transfer occurs.
REQ-020 ARB_FIXED grants the lowest-index valid channel; the pointer is unused.
REQ-021 A transfer in cycle T drives bus_cmd_valid=1 with the captured op, addr and wr_data in cycle T+1 (registered, one-cycle latency).
REQ-022 With no transfer in cycle T, bus_cmd_valid is 0 in T+1 and bus_op, bus_addr and bus_wr_data hold their last values.
REQ-023 A read on the bus in cycle B pushes {valid, channel index} into a tag shift pipeline RD_LATENCY deep.
REQ-024 bus_rd_data is sampled in cycle B+RD_LATENCY; ch_rd_data takes that value and ch_rd_valid[index]=1 in cycle B+RD_LATENCY+1, for exactly one cycle.
REQ-025 Writes produce no read return.
REQ-026 Back-to-back reads, one per cycle from any mix of channels, return in issue order with no bubbles or loss.
REQ-027 ch_rd_data holds its last value when no read return is active.

Reset
REQ-028 While rst=1: ch_cmd_ready=0, bus_cmd_valid=0, bus_op=0, bus_addr=0, bus_wr_data=0, ch_rd_valid=0, ch_rd_data=0, pointer=0, tag pipeline cleared.
REQ-029 Reset mid-operation discards in-flight read tags; no ch_rd_valid is asserted for commands issued before reset.
REQ-030 The first cycle after rst deasserts arbitrates normally with pointer=0.

Structure
REQ-031 Package bus_pkg holds BUS_RD/BUS_WR, ARB_RR/ARB_FIXED and the channel-index width function clog2(NUM_CH).
REQ-032 Sub-module bus_arb_pick, a combinational one-hot picker parameterised by NUM_CH and ARB_MODE, takes requests and pointer and returns grant and index.

Verification
REQ-033 NUM_CH=4, RD_LATENCY=2, ARB_RR: all four channels hold valid continuously -> grants 0,1,2,3,0,1 on consecutive cycles.
REQ-034 ARB_FIXED: ch1 and ch3 valid for 3 cycles -> ch1 granted all 3 cycles, ch3 never granted.
REQ-035 ch2 write addr 0x0010, data 0xBEEF at T -> bus_cmd_valid=1, bus_op=1, bus_addr=0x0010, bus_wr_data=0xBEEF at T+1, no ch_rd_valid.
REQ-036 ch0 read at T, ch3 read at T+1, bus_rd_data=0x1111 at T+3, 0x3333 at T+4 -> ch_rd_valid[0] with 0x1111 at T+4, ch_rd_valid[3] with 0x3333 at T+5.
REQ-037 Pointer=3, only ch3 and ch0 valid -> ch3 granted, then ch0 (wrap).
REQ-038 ch1 read issued, rst pulsed for 1 cycle before the return -> no ch_rd_valid; all outputs 0 during reset.
